// File: rtl/fb_line_scanout.sv
// ---------------------------------------------------------------------------
// fb_line_scanout
//   Scans a 240x160 24-bit framebuffer out to a 640x480 VGA raster at 2x
//   scale. Source rows are prefetched into a two-bank line buffer. Row s
//   goes to bank s[0], so the fetch of the next row never touches the bank
//   that is currently on screen.
//
// Ports
//   Clk          system clock, everything on posedge
//   Reset        asynchronous active-low reset
//   pix_stb      one-cycle pixel advance strobe; DRAWX/DRAWY sampled with it
//   DRAWX/DRAWY  current raster coordinates (800x525 raster)
//   fb_rd_req    framebuffer read request (high while fetching)
//   fb_rd_addr   framebuffer word address, row*240+col
//   fb_rd_gnt    request accepted this cycle; data follows one Clk later
//   fb_rd_data   framebuffer read data
//   R/G/B        registered pixel colour
//   underrun     sticky error: missing line data or fetch aborted
//   fetch_busy   a line fetch is in progress
// ---------------------------------------------------------------------------
module fb_line_scanout (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_stb,
  input  logic [9:0]  DRAWX,
  input  logic [9:0]  DRAWY,
  output logic        fb_rd_req,
  output logic [18:0] fb_rd_addr,
  input  logic        fb_rd_gnt,
  input  logic [23:0] fb_rd_data,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        underrun,
  output logic        fetch_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_row;
  logic [7:0]  r_col;
  logic [1:0]  r_valid;
  logic        r_wrPend;
  logic [7:0]  r_wrCol;
  logic        r_wrBank;
  logic [23:0] r_rgb;
  logic        r_underrun;
  logic [23:0] r_lineBuf [0:1][0:239];

  logic [9:0]  w_trigDy;
  logic        w_trig;
  logic [7:0]  w_trigRow;
  logic [9:0]  w_dispDx;
  logic [9:0]  w_dispDy;
  logic        w_inWin;
  logic [7:0]  w_dispCol;
  logic        w_dispBank;
  logic        w_gnt;

  // A fetch for row s starts two raster lines before that row is shown,
  // at DRAWX==0 on DRAWY = 78 + 2s.
  assign w_trigDy  = DRAWY - 10'd78;
  assign w_trig    = pix_stb && (DRAWX == 10'd0) && (DRAWY >= 10'd78) &&
                     (w_trigDy <= 10'd318) && !w_trigDy[0];
  assign w_trigRow = w_trigDy[8:1];

  assign w_dispDx   = DRAWX - 10'd80;
  assign w_dispDy   = DRAWY - 10'd80;
  assign w_inWin    = (DRAWX >= 10'd80) && (w_dispDx < 10'd480) &&
                      (DRAWY >= 10'd80) && (w_dispDy < 10'd320);
  assign w_dispCol  = w_dispDx[8:1];
  assign w_dispBank = w_dispDy[1];

  assign w_gnt      = (r_state == ST_REQ) && fb_rd_gnt;

  assign fb_rd_req  = (r_state == ST_REQ);
  assign fetch_busy = (r_state != ST_IDLE);
  assign fb_rd_addr = ({11'd0, r_row} * 19'd240) + {11'd0, r_col};
  assign R          = r_rgb[23:16];
  assign G          = r_rgb[15:8];
  assign B          = r_rgb[7:0];
  assign underrun   = r_underrun;

  // Fetch FSM. A new trigger always wins, which also covers the abort case:
  // the old bank keeps its cleared valid bit and the new row restarts at c=0.
  // The column of each grant is remembered so the data arriving one cycle
  // later lands in the right place; clearing r_wrPend in reset drops it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_row    <= 8'd0;
      r_col    <= 8'd0;
      r_valid  <= 2'b00;
      r_wrPend <= 1'b0;
      r_wrCol  <= 8'd0;
      r_wrBank <= 1'b0;
    end else begin
      r_wrPend <= w_gnt;
      if (w_gnt) begin
        r_wrCol  <= r_col;
        r_wrBank <= r_row[0];
      end
      if (w_trig) begin
        r_state               <= ST_REQ;
        r_row                 <= w_trigRow;
        r_col                 <= 8'd0;
        r_valid[w_trigRow[0]] <= 1'b0;
      end else begin
        case (r_state)
          ST_REQ: begin
            if (fb_rd_gnt) begin
              if (r_col == 8'd239) r_state <= ST_DRAIN;
              else                 r_col   <= r_col + 8'd1;
            end
          end
          ST_DRAIN: begin
            r_valid[r_row[0]] <= 1'b1;
            r_state           <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Line buffer write port; contents need no reset.
  always_ff @(posedge Clk) begin
    if (r_wrPend) r_lineBuf[r_wrBank][r_wrCol] <= fb_rd_data;
  end

  // Pixel output register, updated only on pix_stb so it holds between
  // strobes. An in-window pixel from an invalid bank shows black.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rgb <= 24'd0;
    end else if (pix_stb) begin
      if (w_inWin && r_valid[w_dispBank]) r_rgb <= r_lineBuf[w_dispBank][w_dispCol];
      else                                r_rgb <= 24'd0;
    end
  end

  // Sticky underrun: retrigger during a fetch, or missing line data on screen.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_underrun <= 1'b0;
    end else if ((w_trig && (r_state != ST_IDLE)) ||
                 (pix_stb && w_inWin && !r_valid[w_dispBank])) begin
      r_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_line_scanout.sv
// ---------------------------------------------------------------------------
// tb_fb_line_scanout
//   Self-checking bench for fb_line_scanout. A framebuffer responder serves
//   read requests (data = address, or random words) under several grant
//   patterns. A behavioural model keeps per-bank snapshots of whole source
//   rows and predicts pixels and the sticky underrun flag.
// ---------------------------------------------------------------------------
module tb_fb_line_scanout;

  logic        Clk;
  logic        Reset;
  logic        pix_stb;
  logic [9:0]  DRAWX;
  logic [9:0]  DRAWY;
  logic        fb_rd_req;
  logic [18:0] fb_rd_addr;
  logic        fb_rd_gnt;
  logic [23:0] fb_rd_data;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        underrun;
  logic        fetch_busy;

  fb_line_scanout dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pix_stb    (pix_stb),
    .DRAWX      (DRAWX),
    .DRAWY      (DRAWY),
    .fb_rd_req  (fb_rd_req),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_gnt  (fb_rd_gnt),
    .fb_rd_data (fb_rd_data),
    .R          (R),
    .G          (G),
    .B          (B),
    .underrun   (underrun),
    .fetch_busy (fetch_busy)
  );

  int errors = 0;
  int checks = 0;

  // framebuffer and grant pattern
  logic [23:0] rndMem [0:38399];
  bit          patMode = 1'b1;
  int          gntMode = 0;
  int          gntPhase = 0;
  int          grantCount = 0;
  int          expAddr = 0;
  int          addrErr = 0;
  int          gntBase = 0;

  // behavioural model
  bit          mValid [0:1];
  logic [23:0] mLine [0:1][0:239];
  bit          mUnder;
  bit          mBusy;
  int          mRow;

  typedef struct {
    int          fetch;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl [0:14];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] fbWord(input int addr);
    if (addr < 0 || addr > 38399) return 24'd0;
    return patMode ? 24'(addr) : rndMem[addr];
  endfunction

  function automatic logic [23:0] expPix(input int x, input int y);
    int col;
    int s;
    if (x < 80 || x > 559 || y < 80 || y > 399) return 24'd0;
    col = (x - 80) / 2;
    s   = (y - 80) / 2;
    if (!mValid[s % 2]) return 24'd0;
    return mLine[s % 2][col];
  endfunction

  always @(negedge Clk) begin
    gntPhase++;
    case (gntMode)
      0:       fb_rd_gnt = 1'b1;
      1:       fb_rd_gnt = (gntPhase % 4 == 0);
      2:       fb_rd_gnt = 1'b0;
      default: fb_rd_gnt = 1'($urandom_range(0, 1));
    endcase
  end

  // Framebuffer responder: data appears one Clk after each grant.
  always @(posedge Clk) begin
    if (Reset && fb_rd_req && fb_rd_gnt) begin
      grantCount++;
      if (int'(fb_rd_addr) != expAddr) addrErr++;
      expAddr++;
      fb_rd_data <= fbWord(int'(fb_rd_addr));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One pixel strobe, then check colour, underrun and hold.
  task automatic applyStimulus(input int x, input int y, input logic [23:0] exp);
    bit inw;
    inw = (x >= 80 && x <= 559 && y >= 80 && y <= 399);
    if (inw && !mValid[((y - 80) / 2) % 2]) mUnder = 1'b1;
    @(negedge Clk);
    pix_stb = 1'b1;
    DRAWX   = 10'(x);
    DRAWY   = 10'(y);
    @(negedge Clk);
    pix_stb = 1'b0;
    DRAWX   = 10'd700;
    checkOutput($sformatf("rgb(%0d,%0d)", x, y), {8'd0, R, G, B}, {8'd0, exp});
    checkOutput("underrun", {31'd0, underrun}, {31'd0, mUnder});
    @(negedge Clk);
    checkOutput("rgbHold", {8'd0, R, G, B}, {8'd0, exp});
  endtask

  task automatic trigger(input int s);
    @(negedge Clk);
    pix_stb = 1'b1;
    DRAWX   = 10'd0;
    DRAWY   = 10'(78 + 2 * s);
    @(negedge Clk);
    pix_stb = 1'b0;
    DRAWX   = 10'd700;
    expAddr = s * 240;
    addrErr = 0;
    gntBase = grantCount;
    if (mBusy) mUnder = 1'b1;
    mValid[s % 2] = 1'b0;
    mRow  = s;
    mBusy = 1'b1;
  endtask

  task automatic finishFetch();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!fetch_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL fetchDone: got busy after 4000 cycles, expected idle");
    end
    mValid[mRow % 2] = 1'b1;
    for (int c = 0; c < 240; c++) mLine[mRow % 2][c] = fbWord(mRow * 240 + c);
    mBusy = 1'b0;
    checkOutput("grantsPerRow", 32'(grantCount - gntBase), 32'd240);
    checkOutput("addrSeq", 32'(addrErr), 32'd0);
  endtask

  task automatic fetchRow(input int s);
    trigger(s);
    finishFetch();
  endtask

  task automatic modelReset();
    mValid[0] = 1'b0;
    mValid[1] = 1'b0;
    mUnder    = 1'b0;
    mBusy     = 1'b0;
    mRow      = 0;
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 38400; i++) rndMem[i] = 24'($urandom);
    tbl[0]  = '{0,   83,  81, 24'd1};
    tbl[1]  = '{-1,  80,  80, 24'd0};
    tbl[2]  = '{-1,  82,  81, 24'd1};
    tbl[3]  = '{-1, 559,  80, 24'd239};
    tbl[4]  = '{-1,  79,  80, 24'd0};
    tbl[5]  = '{-1, 560,  80, 24'd0};
    tbl[6]  = '{-1,  80,  79, 24'd0};
    tbl[7]  = '{1,   80,  82, 24'd240};
    tbl[8]  = '{-1, 559,  83, 24'd479};
    tbl[9]  = '{-1, 300,  81, 24'd110};
    tbl[10] = '{159, 559, 399, 24'd38399};
    tbl[11] = '{-1,  80, 398, 24'd38160};
    tbl[12] = '{-1, 559, 400, 24'd0};
    tbl[13] = '{-1, 559, 398, 24'd38399};
    tbl[14] = '{-1,  83,  81, 24'd1};

    modelReset();
    Reset   = 1'b0;
    pix_stb = 1'b0;
    DRAWX   = 10'd700;
    DRAWY   = 10'd0;
    repeat (3) @(negedge Clk);
    checkOutput("resetRgb", {8'd0, R, G, B}, 32'd0);
    checkOutput("resetUnderrun", {31'd0, underrun}, 32'd0);
    checkOutput("resetBusy", {31'd0, fetch_busy}, 32'd0);
    checkOutput("resetReq", {31'd0, fb_rd_req}, 32'd0);
    checkOutput("resetAddr", {13'd0, fb_rd_addr}, 32'd0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Table-driven: data = address, grant every cycle.
    patMode = 1'b1;
    gntMode = 0;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].fetch >= 0) fetchRow(tbl[i].fetch);
      applyStimulus(tbl[i].x, tbl[i].y, tbl[i].exp);
    end

    // Randomized: random image, random and 1-in-4 grant patterns.
    patMode = 1'b0;
    gntMode = 3;
    fetchRow(2 * $urandom_range(0, 79));
    fetchRow(2 * $urandom_range(0, 79) + 1);
    for (int r = 0; r < 6; r++) begin
      gntMode = (r % 2 == 1) ? 1 : 3;
      fetchRow($urandom_range(0, 159));
      for (int p = 0; p < 6; p++) begin
        int x;
        int y;
        x = $urandom_range(70, 570);
        y = $urandom_range(76, 403);
        applyStimulus(x, y, expPix(x, y));
      end
    end

    // Starvation: no grants while row 0 should be loading.
    gntMode = 2;
    trigger(0);
    repeat (20) @(negedge Clk);
    applyStimulus(80, 80, expPix(80, 80));
    gntMode = 0;
    finishFetch();
    applyStimulus(85, 81, expPix(85, 81));

    // Re-trigger mid-fetch: row 0 aborted, row 1 fetched in full.
    gntMode = 1;
    trigger(0);
    repeat (60) @(negedge Clk);
    trigger(1);
    checkOutput("underrunRetrig", {31'd0, underrun}, 32'd1);
    finishFetch();
    applyStimulus(80, 80, expPix(80, 80));
    applyStimulus(559, 83, expPix(559, 83));

    // Reset in the middle of a fetch, away from any clock edge.
    gntMode = 0;
    trigger(0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (grantCount - gntBase >= 100) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL grantWait: got %0d grants, expected 100", grantCount - gntBase);
    end
    #2 Reset = 1'b0;
    #1;
    checkOutput("asyncReqDrop", {31'd0, fb_rd_req}, 32'd0);
    checkOutput("asyncBusyDrop", {31'd0, fetch_busy}, 32'd0);
    checkOutput("asyncUnderrun", {31'd0, underrun}, 32'd0);
    modelReset();
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(200, 200, 24'd0);
    fetchRow(0);
    applyStimulus(100, 80, expPix(100, 80));
    applyStimulus(559, 81, expPix(559, 81));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
